cmd_dispatch: RTL and testbench

Parametrised custom-instruction dispatcher between the CPU command/response port and NUM_ENG accelerator engines (tinyML accelerator in slot 0, user engines above). Routes each command by the top bits of cmd_function_id, tracks issue order in a tag FIFO, and returns responses strictly in issue order. Merges engine interrupts into one registered cmd_int. Replaces the fixed two-way bit-9 split with N-way routing, bounded outstanding commands and ordered response return.

---
 rtl/cmd_dispatch_pkg.sv | 34 +++
 rtl/cmd_tag_fifo.sv | 68 ++++++
 rtl/cmd_dispatch.sv | 159 +++++++++++++++
 tb/tb_cmd_dispatch.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_dispatch_pkg.sv
// cmd_dispatch_pkg: shared widths and helpers for the custom-instruction
// dispatcher. The select and tag widths are functions of the engine count.
// The tag MSB marks an error tag, which is only used when
// CMD_DISPATCH_ERR_RSP_EN is defined.
package cmd_dispatch_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FID_W   = 10;
    localparam int unsigned MAX_ENG = 16;

    // Engine-select width taken from the top of the function ID.
    function automatic int unsigned sel_w(input int unsigned num_eng);
        return $clog2(num_eng);
    endfunction

    // Tag width is the engine select plus one error-marker bit.
    function automatic int unsigned tag_w(input int unsigned num_eng);
        return sel_w(num_eng) + 1;
    endfunction

    // Bit position of the error marker inside a tag.
    function automatic int unsigned err_bit(input int unsigned num_eng);
        return sel_w(num_eng);
    endfunction

    // Extract engine idx's response word from a zero-extended packed bus.
    function automatic logic [DATA_W-1:0] rsp_slice(
        input logic [DATA_W*MAX_ENG-1:0] bus,
        input int unsigned               idx
    );
        return bus[DATA_W*idx +: DATA_W];
    endfunction

endpackage

// File: rtl/cmd_tag_fifo.sv
// cmd_tag_fifo: synchronous tag FIFO recording the issue order of commands.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears pointers/count)
//   push, push_data write one tag (ignored when full unless popping too)
//   pop             remove the head tag (ignored when empty)
//   head            current head tag (valid only while count != 0)
//   count           number of stored tags
// Simultaneous push and pop leaves count unchanged, including when full.
module cmd_tag_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Tag storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: routes CPU custom-instruction commands to NUM_ENG engines by
// the top bits of cmd_function_id and returns responses strictly in issue
// order using a tag FIFO of depth MAX_OUTST.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready                CPU command handshake
//   cmd_function_id, cmd_inputs_0/1    CPU command payload
//   rsp_valid/rsp_ready, rsp_outputs_0 CPU response handshake and data
//   cmd_int                            registered OR of eng_int
//   eng_cmd_valid/eng_cmd_ready        per-engine command handshake
//   eng_cmd_function_id, eng_cmd_inputs_0/1  broadcast command payload
//   eng_rsp_valid/eng_rsp_ready        per-engine response handshake
//   eng_rsp_outputs_0                  packed responses, engine i at [32*i +: 32]
//   eng_int                            per-engine interrupts
// Macro CMD_DISPATCH_ERR_RSP_EN: unmapped function IDs are accepted locally
// and answered with ERR_RSP in order; otherwise they go to engine NUM_ENG-1.
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int unsigned NUM_ENG   = 4,
    parameter int unsigned MAX_OUTST = 4,
    parameter logic [31:0] ERR_RSP   = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [9:0]               cmd_function_id,
    input  logic [31:0]              cmd_inputs_0,
    input  logic [31:0]              cmd_inputs_1,
    output logic                     cmd_ready,
    output logic                     cmd_int,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_outputs_0,
    input  logic                     rsp_ready,
    output logic [NUM_ENG-1:0]       eng_cmd_valid,
    input  logic [NUM_ENG-1:0]       eng_cmd_ready,
    output logic [9:0]               eng_cmd_function_id,
    output logic [31:0]              eng_cmd_inputs_0,
    output logic [31:0]              eng_cmd_inputs_1,
    input  logic [NUM_ENG-1:0]       eng_rsp_valid,
    input  logic [32*NUM_ENG-1:0]    eng_rsp_outputs_0,
    output logic [NUM_ENG-1:0]       eng_rsp_ready,
    input  logic [NUM_ENG-1:0]       eng_int
);

    localparam int unsigned SEL_W   = sel_w(NUM_ENG);
    localparam int unsigned TAG_W   = tag_w(NUM_ENG);
    localparam int unsigned ERR_BIT = err_bit(NUM_ENG);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTST) + 1;

    logic [SEL_W-1:0]          sel;
    logic                      mapped;
    logic [TAG_W-1:0]          push_tag;
    logic [TAG_W-1:0]          head_tag;
    logic [SEL_W-1:0]          head_sel;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;
    logic                      permitted;
    logic                      push;
    logic                      pop;
    logic [DATA_W*MAX_ENG-1:0] rsp_bus;

    assign sel       = cmd_function_id[FID_W-1 -: SEL_W];
    assign mapped    = ({1'b0, sel} < TAG_W'(NUM_ENG));
    assign full      = (count == CNT_W'(MAX_OUTST));
    assign empty     = (count == '0);
    // A response leaving this cycle frees a slot for a same-cycle issue.
    assign permitted = ~full | pop;
    assign push      = cmd_valid & cmd_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign head_sel  = head_tag[SEL_W-1:0];
    assign rsp_bus   = (DATA_W*MAX_ENG)'(eng_rsp_outputs_0);

    assign eng_cmd_function_id = cmd_function_id;
    assign eng_cmd_inputs_0    = cmd_inputs_0;
    assign eng_cmd_inputs_1    = cmd_inputs_1;

`ifndef CMD_DISPATCH_ERR_RSP_EN
    logic [SEL_W-1:0] eff_sel;
    // Unmapped selects fall through to the last (catch-all) engine slot.
    assign eff_sel = mapped ? sel : SEL_W'(NUM_ENG - 1);
`endif

    // Command routing and tag generation.
    always_comb begin
        eng_cmd_valid = '0;
        cmd_ready     = 1'b0;
        push_tag      = '0;
`ifdef CMD_DISPATCH_ERR_RSP_EN
        if (mapped) begin
            for (int i = 0; i < int'(NUM_ENG); i++) begin
                if (sel == SEL_W'(i)) begin
                    eng_cmd_valid[i] = cmd_valid & permitted;
                    cmd_ready        = permitted & eng_cmd_ready[i];
                end
            end
            push_tag = {1'b0, sel};
        end else begin
            cmd_ready = permitted;
            push_tag  = {1'b1, sel};
        end
`else
        for (int i = 0; i < int'(NUM_ENG); i++) begin
            if (eff_sel == SEL_W'(i)) begin
                eng_cmd_valid[i] = cmd_valid & permitted;
                cmd_ready        = permitted & eng_cmd_ready[i];
            end
        end
        push_tag = {1'b0, eff_sel};
`endif
    end

    // In-order response return: only the engine owning the head tag is heard.
    always_comb begin
        rsp_valid     = 1'b0;
        rsp_outputs_0 = '0;
        eng_rsp_ready = '0;
        if (!empty) begin
            if (head_tag[ERR_BIT]) begin
`ifdef CMD_DISPATCH_ERR_RSP_EN
                rsp_valid     = 1'b1;
                rsp_outputs_0 = ERR_RSP;
`endif
            end else begin
                for (int i = 0; i < int'(NUM_ENG); i++) begin
                    if (head_sel == SEL_W'(i)) begin
                        rsp_valid        = eng_rsp_valid[i];
                        eng_rsp_ready[i] = rsp_ready;
                    end
                end
                rsp_outputs_0 = rsp_slice(rsp_bus, 32'(head_sel));
            end
        end
    end

    // Merged interrupt, one cycle behind the engines.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_int <= 1'b0;
        end else begin
            cmd_int <= |eng_int;
        end
    end

    cmd_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_tag),
        .pop       (pop),
        .head      (head_tag),
        .count     (count)
    );

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed checks of cmd_dispatch (NUM_ENG=3, MAX_OUTST=4)
// followed by a randomized engine-latency run against an issue-order
// scoreboard. Builds with or without CMD_DISPATCH_ERR_RSP_EN.
module tb_cmd_dispatch;

    localparam int NE    = 3;
    localparam int NCMD  = 2000;
    localparam int BUDGET = 60000;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic [9:0]        cmd_function_id;
    logic [31:0]       cmd_inputs_0;
    logic [31:0]       cmd_inputs_1;
    logic              cmd_ready;
    logic              cmd_int;
    logic              rsp_valid;
    logic [31:0]       rsp_outputs_0;
    logic              rsp_ready;
    logic [NE-1:0]     eng_cmd_valid;
    logic [NE-1:0]     eng_cmd_ready;
    logic [9:0]        eng_cmd_function_id;
    logic [31:0]       eng_cmd_inputs_0;
    logic [31:0]       eng_cmd_inputs_1;
    logic [NE-1:0]     eng_rsp_valid;
    logic [32*NE-1:0]  eng_rsp_outputs_0;
    logic [NE-1:0]     eng_rsp_ready;
    logic [NE-1:0]     eng_int;

    // Engine side is driven either by directed steps or by the engine model.
    logic              auto_mode;
    logic [NE-1:0]     man_cmd_ready, man_rsp_valid;
    logic [32*NE-1:0]  man_rsp_data;
    logic [NE-1:0]     auto_cmd_ready, auto_rsp_valid;
    logic [32*NE-1:0]  auto_rsp_data;

    assign eng_cmd_ready     = auto_mode ? auto_cmd_ready : man_cmd_ready;
    assign eng_rsp_valid     = auto_mode ? auto_rsp_valid : man_rsp_valid;
    assign eng_rsp_outputs_0 = auto_mode ? auto_rsp_data  : man_rsp_data;

    always #5 clk = ~clk;

    cmd_dispatch #(
        .NUM_ENG   (NE),
        .MAX_OUTST (4),
        .ERR_RSP   (32'hFFFF_FFFF)
    ) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_function_id     (cmd_function_id),
        .cmd_inputs_0        (cmd_inputs_0),
        .cmd_inputs_1        (cmd_inputs_1),
        .cmd_ready           (cmd_ready),
        .cmd_int             (cmd_int),
        .rsp_valid           (rsp_valid),
        .rsp_outputs_0       (rsp_outputs_0),
        .rsp_ready           (rsp_ready),
        .eng_cmd_valid       (eng_cmd_valid),
        .eng_cmd_ready       (eng_cmd_ready),
        .eng_cmd_function_id (eng_cmd_function_id),
        .eng_cmd_inputs_0    (eng_cmd_inputs_0),
        .eng_cmd_inputs_1    (eng_cmd_inputs_1),
        .eng_rsp_valid       (eng_rsp_valid),
        .eng_rsp_outputs_0   (eng_rsp_outputs_0),
        .eng_rsp_ready       (eng_rsp_ready),
        .eng_int             (eng_int)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // What engine i returns for operand x.
    function automatic logic [31:0] eng_fn(input logic [31:0] x, input int i);
        return x ^ {4'(i + 1), 28'h0};
    endfunction

    // Expected CPU response for a command, from the routing rules.
    function automatic logic [31:0] exp_rsp(input logic [9:0] id, input logic [31:0] x);
        int s;
        s = int'(id[9:8]);
`ifdef CMD_DISPATCH_ERR_RSP_EN
        if (s >= NE) return 32'hFFFF_FFFF;
`else
        if (s >= NE) s = NE - 1;
`endif
        return eng_fn(x, s);
    endfunction

    // Engine model: per-engine FIFO of pending results with random latency.
    logic [31:0] eb   [NE][8];
    int          ecnt [NE];
    int          ehd  [NE];
    int          dly  [NE];

    always @(posedge clk) begin
        for (int i = 0; i < NE; i++) begin
            if (!auto_mode) begin
                ecnt[i] = 0;
                ehd[i]  = 0;
                dly[i]  = 0;
                auto_cmd_ready[i] <= 1'b1;
                auto_rsp_valid[i] <= 1'b0;
                auto_rsp_data[32*i +: 32] <= 32'h0;
            end else begin
                if (eng_rsp_valid[i] && eng_rsp_ready[i]) begin
                    ehd[i]  = (ehd[i] + 1) % 8;
                    ecnt[i] = ecnt[i] - 1;
                    dly[i]  = int'($urandom_range(20));
                end else if (dly[i] > 0) begin
                    dly[i] = dly[i] - 1;
                end
                if (eng_cmd_valid[i] && eng_cmd_ready[i]) begin
                    if (ecnt[i] == 0) dly[i] = int'($urandom_range(20));
                    eb[i][(ehd[i] + ecnt[i]) % 8] = eng_fn(eng_cmd_inputs_0, i);
                    ecnt[i] = ecnt[i] + 1;
                end
                auto_cmd_ready[i] <= ($urandom_range(3) != 0);
                auto_rsp_valid[i] <= (ecnt[i] != 0) && (dly[i] == 0);
                auto_rsp_data[32*i +: 32] <= eb[i][ehd[i]];
            end
        end
    end

    logic [31:0] sb [$];
    logic [9:0]  cur_id;
    logic [31:0] cur_in0;
    logic        holding;
    int          issued;
    int          cyc;

    initial begin
        auto_mode       = 1'b0;
        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_function_id = 10'h000;
        cmd_inputs_0    = 32'h0;
        cmd_inputs_1    = 32'h0;
        rsp_ready       = 1'b0;
        man_cmd_ready   = '1;
        man_rsp_valid   = '0;
        man_rsp_data    = '0;
        eng_int         = '0;
        step();
        step();
        chk("reset_cmd_int", 32'(cmd_int), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("empty_eng_rsp_ready", 32'(eng_rsp_ready), 32'h0);

        // In-order return with engines answering 2,1,0.
        rsp_ready       = 1'b0;
        cmd_valid       = 1'b1;
        cmd_function_id = 10'h000;
        cmd_inputs_0    = 32'h11;
        #1;
        chk("t1_c0_eng_valid", 32'(eng_cmd_valid), 32'h1);
        chk("t1_c0_ready", 32'(cmd_ready), 32'h1);
        chk("t1_c0_bcast", eng_cmd_inputs_0, 32'h11);
        step();
        cmd_function_id = 10'h100;
        #1;
        chk("t1_c1_eng_valid", 32'(eng_cmd_valid), 32'h2);
        step();
        cmd_function_id = 10'h200;
        #1;
        chk("t1_c2_eng_valid", 32'(eng_cmd_valid), 32'h4);
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        man_rsp_valid = 3'b100;
        man_rsp_data[64 +: 32] = 32'hA2;
        #1;
        chk("t1_e2_first_valid", 32'(rsp_valid), 32'h0);
        chk("t1_head_ready", 32'(eng_rsp_ready), 32'h1);
        step();
        man_rsp_valid = 3'b110;
        man_rsp_data[32 +: 32] = 32'hA1;
        #1;
        chk("t1_e1_valid", 32'(rsp_valid), 32'h0);
        step();
        man_rsp_valid = 3'b111;
        man_rsp_data[0 +: 32] = 32'hA0;
        #1;
        chk("t1_r0_valid", 32'(rsp_valid), 32'h1);
        chk("t1_r0_data", rsp_outputs_0, 32'hA0);
        step();
        man_rsp_valid = 3'b110;
        #1;
        chk("t1_r1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_r1_data", rsp_outputs_0, 32'hA1);
        chk("t1_r1_eng_ready", 32'(eng_rsp_ready), 32'h2);
        step();
        man_rsp_valid = 3'b100;
        #1;
        chk("t1_r2_data", rsp_outputs_0, 32'hA2);
        step();
        man_rsp_valid = 3'b000;
        #1;
        chk("t1_empty_ready", 32'(eng_rsp_ready), 32'h0);

        // Fill to MAX_OUTST, then pop and push together.
        rsp_ready       = 1'b0;
        cmd_valid       = 1'b1;
        cmd_function_id = 10'h000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_fill_ready", 32'(cmd_ready), 32'h1);
            step();
        end
        #1;
        chk("t2_full_ready", 32'(cmd_ready), 32'h0);
        chk("t2_full_eng_valid", 32'(eng_cmd_valid), 32'h0);
        man_rsp_valid = 3'b001;
        man_rsp_data[0 +: 32] = 32'hB0;
        rsp_ready = 1'b1;
        #1;
        chk("t2_pp_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t2_pp_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("t2_pp_eng_valid", 32'(eng_cmd_valid), 32'h1);
        step();
        rsp_ready = 1'b0;
        #1;
        chk("t2_still_full", 32'(cmd_ready), 32'h0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_drain_valid", 32'(rsp_valid), 32'h1);
            step();
        end
        #1;
        chk("t2_drained_valid", 32'(rsp_valid), 32'h0);
        chk("t2_drained_ready", 32'(eng_rsp_ready), 32'h0);
        man_rsp_valid = 3'b000;

        // Engine backpressure while empty.
        cmd_valid       = 1'b1;
        cmd_function_id = 10'h100;
        man_cmd_ready   = 3'b101;
        #1;
        chk("t3_bp_ready", 32'(cmd_ready), 32'h0);
        chk("t3_bp_eng_valid", 32'(eng_cmd_valid), 32'h2);
        man_cmd_ready = 3'b111;
        #1;
        chk("t3_go_ready", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 1'b0;
        man_rsp_valid = 3'b010;
        man_rsp_data[32 +: 32] = 32'hC1;
        #1;
        chk("t3_rsp_data", rsp_outputs_0, 32'hC1);
        step();
        man_rsp_valid = 3'b000;

        // Unmapped function ID (sel=3 with three engines).
        rsp_ready       = 1'b0;
        cmd_valid       = 1'b1;
        cmd_function_id = 10'h3C0;
        #1;
`ifdef CMD_DISPATCH_ERR_RSP_EN
        chk("t4_err_ready", 32'(cmd_ready), 32'h1);
        chk("t4_err_eng_valid", 32'(eng_cmd_valid), 32'h0);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("t4_err_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t4_err_rsp_data", rsp_outputs_0, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        #1;
        chk("t4_err_eng_ready", 32'(eng_rsp_ready), 32'h0);
        step();
`else
        chk("t4_fold_eng_valid", 32'(eng_cmd_valid), 32'h4);
        chk("t4_fold_ready", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 1'b0;
        man_rsp_valid = 3'b100;
        man_rsp_data[64 +: 32] = 32'hC2;
        rsp_ready = 1'b1;
        #1;
        chk("t4_fold_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t4_fold_rsp_data", rsp_outputs_0, 32'hC2);
        chk("t4_fold_eng_ready", 32'(eng_rsp_ready), 32'h4);
        step();
        man_rsp_valid = 3'b000;
`endif
        #1;
        chk("t4_after_valid", 32'(rsp_valid), 32'h0);

        // Interrupt merge latency.
        eng_int = 3'b100;
        #1;
        chk("t5_int_same_cycle", 32'(cmd_int), 32'h0);
        step();
        chk("t5_int_rise", 32'(cmd_int), 32'h1);
        eng_int = 3'b000;
        #1;
        chk("t5_int_hold", 32'(cmd_int), 32'h1);
        step();
        chk("t5_int_fall", 32'(cmd_int), 32'h0);

        // Reset with three commands outstanding.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_function_id = 10'h000;
        step();
        cmd_function_id = 10'h100;
        step();
        cmd_function_id = 10'h200;
        step();
        cmd_valid = 1'b0;
        eng_int   = 3'b001;
        man_rsp_valid = 3'b111;
        step();
        chk("t6_pre_int", 32'(cmd_int), 32'h1);
        chk("t6_pre_valid", 32'(rsp_valid), 32'h1);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        eng_int = 3'b000;
        rsp_ready = 1'b1;
        #1;
        chk("t6_rst_int", 32'(cmd_int), 32'h0);
        chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
        chk("t6_rst_eng_ready", 32'(eng_rsp_ready), 32'h0);
        man_rsp_valid = 3'b000;
        cmd_valid       = 1'b1;
        cmd_function_id = 10'h100;
        cmd_inputs_0    = 32'h55;
        #1;
        chk("t6_fresh_eng_valid", 32'(eng_cmd_valid), 32'h2);
        chk("t6_fresh_ready", 32'(cmd_ready), 32'h1);
        step();
        cmd_valid = 1'b0;
        man_rsp_valid = 3'b010;
        man_rsp_data[32 +: 32] = 32'hD1;
        #1;
        chk("t6_fresh_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t6_fresh_rsp_data", rsp_outputs_0, 32'hD1);
        step();
        man_rsp_valid = 3'b000;
        #1;
        chk("t6_fresh_empty", 32'(rsp_valid), 32'h0);
        step();

        // Random IDs, engine latency and backpressure vs. issue-order scoreboard.
        auto_mode = 1'b1;
        holding   = 1'b0;
        issued    = 0;
        cyc       = 0;
        cur_id    = 10'h0;
        cur_in0   = 32'h0;
        while ((issued < NCMD || sb.size() != 0) && cyc < BUDGET) begin
            if (!holding && issued < NCMD && $urandom_range(3) != 0) begin
                cur_id  = 10'($urandom);
                cur_in0 = $urandom;
                holding = 1'b1;
            end
            cmd_valid       = holding;
            cmd_function_id = cur_id;
            cmd_inputs_0    = cur_in0;
            cmd_inputs_1    = ~cur_in0;
            rsp_ready       = ($urandom_range(3) != 0);
            #1;
            if (cmd_valid && cmd_ready) begin
                sb.push_back(exp_rsp(cur_id, cur_in0));
                issued++;
                holding = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                chk("rand_rsp_expected", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) chk("rand_rsp_data", rsp_outputs_0, sb.pop_front());
            end
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("rand_all_issued", 32'(issued), 32'(NCMD));
        chk("rand_sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
